// File: rtl/xintf_pkg.sv
// Shared XINTF constants and mailbox arbiter state encoding.
package xintf_pkg;

    localparam int unsigned XINTF_ADDR_W    = 20;
    localparam int unsigned XINTF_IDX_W     = 4;
    localparam int unsigned XINTF_NREG      = 16;
    localparam logic [19:0] XINTF_BASE_ADDR = 20'h0FC00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INT_ACC  = 3'd1,
        ST_DSP_RD   = 3'd2,
        ST_DSP_WR   = 3'd3,
        ST_DSP_HOLD = 3'd4
    } xintf_state_e;

endpackage

// File: rtl/xintf_rr_arb.sv
// Combinational round-robin grant: first requester after last_gnt wins, one-hot out.
module xintf_rr_arb
    import xintf_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned GW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_gnt,
    output logic [NREQ-1:0] gnt
);

    logic [GW-1:0] k;
    logic          found;

    // Scan requesters starting one past the previous winner, wrapping around.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            k = GW'((32'(last_gnt) + i) % NREQ);
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xintf_bus_arbiter.sv
// Arbitrates the single-port mailbox bank between the DSP XINTF and internal requesters.
module xintf_bus_arbiter
    import xintf_pkg::*;
#(
    parameter int unsigned        ADDR_W    = XINTF_ADDR_W,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(XINTF_BASE_ADDR),
    parameter int unsigned        NREG      = XINTF_NREG,
    parameter int unsigned        IDX_W     = XINTF_IDX_W,
    parameter int unsigned        NREQ      = 2
) (
    input  logic                  clk,
    input  logic                  global_rst,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [ADDR_W-1:0]     xadd,
    input  logic [15:0]           xdata_in,
    output logic [15:0]           xdata_out,
    output logic                  xdata_oe,
    input  logic [NREQ-1:0]       int_req,
    input  logic [NREQ-1:0]       int_we,
    input  logic [NREQ*IDX_W-1:0] int_idx,
    input  logic [NREQ*16-1:0]    int_wdata,
    output logic [NREQ-1:0]       int_done,
    output logic [15:0]           int_rdata,
    output logic                  bank_en,
    output logic                  bank_we,
    output logic [IDX_W-1:0]      bank_idx,
    output logic [15:0]           bank_wdata,
    input  logic [15:0]           bank_rdata,
    output logic                  proto_err
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    xintf_state_e      state, state_nxt;

    logic              ren_m, ren_s, ren_d;
    logic              wen_m, wen_s, wen_d;
    logic              start_rd, start_wr;
    logic [ADDR_W-1:0] xadd_r, addr_r, addr_off;
    logic [15:0]       xdata_r;
    logic              pend_rd, pend_wr;
    logic              dsp_hit;
    logic [IDX_W-1:0]  dsp_idx;

    logic [NREQ-1:0]   gnt_oh;
    logic [GW-1:0]     gnt_i, gnt_r, last_gnt;
    logic [GW-1:0]     enc_acc [NREQ+1];
    logic [IDX_W-1:0]  req_idx [NREQ];
    logic [15:0]       req_wdata [NREQ];
    logic              req_ok;
    logic              int_rd_r, int_ok_r;

    logic              clr_pend, int_issue, int_fin, rd_capture, oe_clr;

    // Unpack per-requester fields and encode the one-hot grant.
    assign enc_acc[0] = '0;
    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign req_idx[g]     = int_idx[g*IDX_W +: IDX_W];
        assign req_wdata[g]   = int_wdata[g*16 +: 16];
        assign enc_acc[g+1]   = enc_acc[g] | (gnt_oh[g] ? GW'(g) : '0);
    end
    assign gnt_i = enc_acc[NREQ];

    xintf_rr_arb #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr_arb (
        .req      (int_req),
        .last_gnt (last_gnt),
        .gnt      (gnt_oh)
    );

    // Strobe falling edges seen after synchronization.
    assign start_rd = ren_d & ~ren_s;
    assign start_wr = wen_d & ~wen_s;

    // Mailbox window decode on the captured DSP address.
    assign addr_off = addr_r - BASE_ADDR;
    assign dsp_hit  = (addr_r >= BASE_ADDR) && (addr_off < ADDR_W'(NREG));
    assign dsp_idx  = addr_off[IDX_W-1:0];
    assign req_ok   = {1'b0, req_idx[gnt_i]} < (IDX_W+1)'(NREG);

    // State register.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bank/requester strobes; everything quiet while in reset.
    always_comb begin
        state_nxt  = state;
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_idx   = '0;
        bank_wdata = '0;
        int_done   = '0;
        int_rdata  = '0;
        clr_pend   = 1'b0;
        int_issue  = 1'b0;
        int_fin    = 1'b0;
        rd_capture = 1'b0;
        oe_clr     = 1'b0;
        if (!global_rst) begin
            case (state)
                ST_IDLE: begin
                    if (pend_rd || pend_wr) begin
                        clr_pend = 1'b1;
                        if (dsp_hit) begin
                            bank_en    = 1'b1;
                            bank_we    = pend_wr;
                            bank_idx   = dsp_idx;
                            bank_wdata = pend_wr ? xdata_r : '0;
                            state_nxt  = pend_wr ? ST_DSP_WR : ST_DSP_RD;
                        end else begin
                            state_nxt  = ST_DSP_HOLD;
                        end
                    end else if (|int_req) begin
                        int_issue  = 1'b1;
                        bank_en    = req_ok;
                        bank_we    = req_ok & int_we[gnt_i];
                        bank_idx   = req_idx[gnt_i];
                        bank_wdata = int_we[gnt_i] ? req_wdata[gnt_i] : '0;
                        state_nxt  = ST_INT_ACC;
                    end
                end
                ST_INT_ACC: begin
                    int_done[gnt_r] = 1'b1;
                    int_fin         = 1'b1;
                    if (int_rd_r && int_ok_r) begin
                        int_rdata = bank_rdata;
                    end
                    state_nxt = ST_IDLE;
                end
                ST_DSP_RD: begin
                    rd_capture = 1'b1;
                    state_nxt  = ST_DSP_HOLD;
                end
                ST_DSP_WR: begin
                    state_nxt = ST_DSP_HOLD;
                end
                ST_DSP_HOLD: begin
                    if (ren_s && wen_s) begin
                        oe_clr    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Synchronizers, pin capture, pending flags, grant bookkeeping and DSP read-back.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            ren_m     <= 1'b1;
            ren_s     <= 1'b1;
            ren_d     <= 1'b1;
            wen_m     <= 1'b1;
            wen_s     <= 1'b1;
            wen_d     <= 1'b1;
            xadd_r    <= '0;
            xdata_r   <= '0;
            addr_r    <= '0;
            pend_rd   <= 1'b0;
            pend_wr   <= 1'b0;
            gnt_r     <= '0;
            int_rd_r  <= 1'b0;
            int_ok_r  <= 1'b0;
            last_gnt  <= GW'(NREQ - 1);
            xdata_out <= '0;
            xdata_oe  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            ren_m     <= ren;
            ren_s     <= ren_m;
            ren_d     <= ren_s;
            wen_m     <= wen;
            wen_s     <= wen_m;
            wen_d     <= wen_s;
            xadd_r    <= xadd;
            xdata_r   <= xdata_in;
            proto_err <= start_rd & start_wr;

            if (start_rd || start_wr) begin
                pend_rd <= start_rd;
                pend_wr <= ~start_rd;
                addr_r  <= xadd_r;
            end else if (clr_pend) begin
                pend_rd <= 1'b0;
                pend_wr <= 1'b0;
            end

            if (int_issue) begin
                gnt_r    <= gnt_i;
                int_rd_r <= ~int_we[gnt_i];
                int_ok_r <= req_ok;
            end
            if (int_fin) begin
                last_gnt <= gnt_r;
            end

            if (rd_capture) begin
                xdata_out <= bank_rdata;
                xdata_oe  <= 1'b1;
            end else if (oe_clr) begin
                xdata_oe  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xintf_bus_arbiter.sv
// Self-checking bench for xintf_bus_arbiter with a behavioural mailbox RAM.
module tb_xintf_bus_arbiter;

    localparam logic [19:0] BASE = 20'h0FC00;

    logic        clk = 1'b0;
    logic        global_rst;
    logic        ren, wen;
    logic [19:0] xadd;
    logic [15:0] xdata_in, xdata_out;
    logic        xdata_oe;
    logic [1:0]  int_req, int_we, int_done;
    logic [7:0]  int_idx;
    logic [31:0] int_wdata;
    logic [15:0] int_rdata;
    logic        bank_en, bank_we;
    logic [3:0]  bank_idx;
    logic [15:0] bank_wdata;
    logic [15:0] bank_rdata = 16'h0;
    logic        proto_err;

    always #5 clk = ~clk;

    xintf_bus_arbiter dut (
        .clk        (clk),
        .global_rst (global_rst),
        .ren        (ren),
        .wen        (wen),
        .xadd       (xadd),
        .xdata_in   (xdata_in),
        .xdata_out  (xdata_out),
        .xdata_oe   (xdata_oe),
        .int_req    (int_req),
        .int_we     (int_we),
        .int_idx    (int_idx),
        .int_wdata  (int_wdata),
        .int_done   (int_done),
        .int_rdata  (int_rdata),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_idx   (bank_idx),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .proto_err  (proto_err)
    );

    // Synchronous single-port mailbox: read data appears one cycle after bank_en.
    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (bank_en) begin
            if (bank_we) mem[bank_idx] <= bank_wdata;
            bank_rdata <= mem[bank_idx];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards.
    typedef struct packed {
        logic        who;
        logic        we;
        logic [15:0] rdata;
    } int_exp_t;

    logic [15:0] dsp_q [$];
    int_exp_t    int_q [$];

    logic        oe_prev = 1'b0;
    logic [15:0] held;
    logic [15:0] exp_d;
    int_exp_t    exp_i;

    // Output monitor: DSP read data on oe rise, hold stability, internal completions.
    always @(negedge clk) begin
        if (xdata_oe && !oe_prev) begin
            if (dsp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dsp_unexpected_read: got %0h expected none", xdata_out);
            end else begin
                exp_d = dsp_q.pop_front();
                check("dsp_rdata", 32'(xdata_out), 32'(exp_d));
            end
            held = xdata_out;
        end else if (xdata_oe && oe_prev) begin
            check("dsp_hold_stable", 32'(xdata_out), 32'(held));
        end
        oe_prev = xdata_oe;

        if (int_done != 2'b00) begin
            if (int_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL int_unexpected_done: got %0b expected none", int_done);
            end else begin
                exp_i = int_q.pop_front();
                check("int_done_onehot", 32'(int_done), 32'(2'b01 << exp_i.who));
                if (!exp_i.we) check("int_rdata", 32'(int_rdata), 32'(exp_i.rdata));
            end
        end
    end

    // kind: 0 write, 1 read, 2 read and write strobes together
    typedef struct {
        logic [1:0]  kind;
        logic [19:0] addr;
        logic [15:0] data;
        logic        hit;
        logic [15:0] rdata;
        int          lat;
        int          int_at;
    } vec_t;

    task automatic dsp_op(input vec_t v);
        int          en_cnt = 0;
        int          we_cnt = 0;
        int          pe_cnt = 0;
        int          lat    = 0;
        int          fall   = 0;
        bit          int_on = 1'b0;
        logic [3:0]  last_idx = '0;
        logic [15:0] last_wd  = '0;
        logic [3:0]  exp_idx;
        exp_idx = 4'(v.addr - BASE);
        xadd     = v.addr;
        xdata_in = v.data;
        if (v.kind != 2'd0 && v.hit) dsp_q.push_back(v.rdata);
        @(negedge clk);
        ren = (v.kind == 2'd0);
        wen = (v.kind == 2'd1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bank_en) begin
                en_cnt++;
                last_idx = bank_idx;
                if (bank_we) begin
                    we_cnt++;
                    last_wd = bank_wdata;
                end
            end
            if (proto_err) pe_cnt++;
            if (xdata_oe && lat == 0) lat = c;
            if (v.int_at == c) begin
                int_we    = 2'b10;
                int_idx   = {4'd7, 4'd0};
                int_wdata = {16'h7777, 16'h0000};
                int_q.push_back('{who: 1'b1, we: 1'b1, rdata: 16'h0});
                int_req   = 2'b10;
                int_on    = 1'b1;
            end else if (int_on && int_done[1]) begin
                int_req = 2'b00;
                int_on  = 1'b0;
            end
        end
        check("bank_en_count", 32'(en_cnt), v.hit ? 32'd1 : 32'd0);
        check("bank_we_count", 32'(we_cnt), (v.hit && v.kind == 2'd0) ? 32'd1 : 32'd0);
        if (v.hit) check("bank_idx", 32'(last_idx), 32'(exp_idx));
        if (v.hit && v.kind == 2'd0) check("bank_wdata", 32'(last_wd), 32'(v.data));
        check("proto_err_count", 32'(pe_cnt), (v.kind == 2'd2) ? 32'd1 : 32'd0);
        check("oe_latency", 32'(lat), (v.kind != 2'd0 && v.hit) ? 32'(v.lat) : 32'd0);
        ren = 1'b1;
        wen = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!xdata_oe && fall == 0) fall = c;
        end
        if (v.kind != 2'd0 && v.hit) check("oe_release", 32'(fall), 32'd3);
    endtask

    vec_t vecs [11];
    vec_t vcol;
    int   done_at [4];
    int   n_done;
    int   seen;

    initial begin
        vecs[0]  = '{2'd0, 20'h0FC03, 16'hA5A5, 1'b1, 16'h0000, 0, -1};
        vecs[1]  = '{2'd1, 20'h0FC03, 16'h0000, 1'b1, 16'hA5A5, 5, -1};
        vecs[2]  = '{2'd1, 20'h0FD00, 16'h0000, 1'b0, 16'h0000, 0, -1};
        vecs[3]  = '{2'd0, 20'h0FC00, 16'h1234, 1'b1, 16'h0000, 0, -1};
        vecs[4]  = '{2'd0, 20'h0FC0F, 16'hBEEF, 1'b1, 16'h0000, 0, -1};
        vecs[5]  = '{2'd1, 20'h0FC0F, 16'h0000, 1'b1, 16'hBEEF, 5, -1};
        vecs[6]  = '{2'd1, 20'h0FC10, 16'h0000, 1'b0, 16'h0000, 0, -1};
        vecs[7]  = '{2'd1, 20'h0FBFF, 16'h0000, 1'b0, 16'h0000, 0, -1};
        vecs[8]  = '{2'd1, 20'h0FC00, 16'h0000, 1'b1, 16'h1234, 5, -1};
        vecs[9]  = '{2'd2, 20'h0FC01, 16'hDEAD, 1'b1, 16'h0000, 5, -1};
        vecs[10] = '{2'd1, 20'h0FC01, 16'h0000, 1'b1, 16'h0000, 5, -1};

        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        global_rst = 1'b1;
        ren = 1'b1;
        wen = 1'b1;
        xadd = '0;
        xdata_in = '0;
        int_req = '0;
        int_we = '0;
        int_idx = '0;
        int_wdata = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_xdata_oe", 32'(xdata_oe), 32'd0);
        check("rst_xdata_out", 32'(xdata_out), 32'd0);
        check("rst_bank_en", 32'(bank_en), 32'd0);
        check("rst_int_done", 32'(int_done), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        global_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) dsp_op(vecs[i]);

        // Both requesters held: grants alternate starting with requester 0.
        int_we    = 2'b00;
        int_idx   = {4'd0, 4'd3};
        int_wdata = '0;
        int_q.push_back('{who: 1'b0, we: 1'b0, rdata: 16'hA5A5});
        int_q.push_back('{who: 1'b1, we: 1'b0, rdata: 16'h1234});
        int_q.push_back('{who: 1'b0, we: 1'b0, rdata: 16'hA5A5});
        int_q.push_back('{who: 1'b1, we: 1'b0, rdata: 16'h1234});
        int_req = 2'b11;
        n_done  = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (int_done != 2'b00 && n_done < 4) begin
                done_at[n_done] = c;
                n_done++;
                if (n_done == 4) int_req = 2'b00;
            end
        end
        int_req = 2'b00;
        check("rr_done_count", 32'(n_done), 32'd4);
        check("rr_first_done_cycle", 32'(done_at[0]), 32'd1);
        for (int k = 0; k < 3; k++) check("rr_done_spacing", 32'(done_at[k+1] - done_at[k]), 32'd2);
        repeat (3) @(negedge clk);

        // DSP read falls while requester 1 is in its access window.
        vcol = '{2'd1, 20'h0FC07, 16'h0000, 1'b1, 16'h7777, 6, 2};
        dsp_op(vcol);

        // Single requester-0 access so the last winner is 0 before reset.
        int_we  = 2'b00;
        int_idx = {4'd0, 4'd3};
        int_q.push_back('{who: 1'b0, we: 1'b0, rdata: 16'hA5A5});
        int_req = 2'b01;
        seen = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (int_done[0] && seen == 0) begin
                seen = c;
                int_req = 2'b00;
            end
        end
        int_req = 2'b00;
        check("single_req0_done", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);

        // Reset while holding a DSP read with xdata_oe high.
        xadd = 20'h0FC03;
        dsp_q.push_back(16'hA5A5);
        @(negedge clk);
        ren  = 1'b0;
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (xdata_oe && seen == 0) seen = c;
            if (seen != 0) break;
        end
        check("hold_before_reset_latency", 32'(seen), 32'd5);
        global_rst = 1'b1;
        ren        = 1'b1;
        int_req    = 2'b11;
        int_idx    = {4'd0, 4'd3};
        @(negedge clk);
        check("oe_after_reset", 32'(xdata_oe), 32'd0);
        check("bank_en_in_reset", 32'(bank_en), 32'd0);
        check("int_done_in_reset", 32'(int_done), 32'd0);
        @(negedge clk);
        int_q.push_back('{who: 1'b0, we: 1'b0, rdata: 16'hA5A5});
        global_rst = 1'b0;
        seen = 0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (int_done != 2'b00 && seen == 0) begin
                seen = c;
                int_req = 2'b00;
            end
        end
        int_req = 2'b00;
        check("grant_after_reset", 32'(seen != 0), 32'd1);
        repeat (4) @(negedge clk);

        check("dsp_q_drained", 32'(dsp_q.size()), 32'd0);
        check("int_q_drained", 32'(int_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
